// File: rtl/step_pulse_gen.sv
// Turns the board's bouncing step pushbutton and run switch into a clean one-cycle
// CPU step strobe, with manual single-step and fixed-rate auto-run modes.
module step_pulse_gen #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 100000,
  parameter int RUN_DIV         = 1000000,
  parameter int CNT_W           = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             btn_in,
  input  logic             run_en,
  output logic             step_pulse,
  output logic [CNT_W-1:0] step_count,
  output logic             btn_level,
  output logic             run_mode
);

  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int DIV_W = $clog2(RUN_DIV);
  localparam logic [DB_W-1:0]  DB_MAX  = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(RUN_DIV - 1);

  typedef enum logic [1:0] {IDLE, HELD, RUN} state_t;

  logic [SYNC_STAGES-1:0] btn_sync_q, btn_sync_d;
  logic [SYNC_STAGES-1:0] run_sync_q, run_sync_d;
  logic [DB_W-1:0]        db_cnt_q, db_cnt_d;
  logic                   btn_level_q, btn_level_d;
  logic [DIV_W-1:0]       div_q, div_d;
  state_t                 state_q, state_d;
  logic                   step_pulse_q, step_pulse_d;
  logic [CNT_W-1:0]       step_count_q, step_count_d;
  logic                   btn_synced;

  assign btn_synced = btn_sync_q[SYNC_STAGES-1];
  assign run_mode   = run_sync_q[SYNC_STAGES-1];
  assign btn_level  = btn_level_q;
  assign step_pulse = step_pulse_q;
  assign step_count = step_count_q;

  always_comb begin
    btn_sync_d  = {btn_sync_q[SYNC_STAGES-2:0], btn_in};
    run_sync_d  = {run_sync_q[SYNC_STAGES-2:0], run_en};
    db_cnt_d    = '0;
    btn_level_d = btn_level_q;
    // Any return to agreement before the count completes discards the run.
    if (btn_synced != btn_level_q) begin
      if (db_cnt_q == DB_MAX) begin
        btn_level_d = ~btn_level_q;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    div_d        = '0;
    step_pulse_d = 1'b0;
    case (state_q)
      // Only a fresh rise can leave btn_level high in IDLE, so level == edge here.
      IDLE: begin
        if (run_mode) begin
          state_d = RUN;
        end else if (btn_level_q) begin
          step_pulse_d = 1'b1;
          state_d      = HELD;
        end
      end
      HELD: begin
        if (run_mode) begin
          state_d = RUN;
        end else if (!btn_level_q) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (!run_mode) begin
          state_d = btn_level_q ? HELD : IDLE;
        end else if (div_q == DIV_MAX) begin
          step_pulse_d = 1'b1;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    step_count_d = step_pulse_d ? step_count_q + CNT_W'(1) : step_count_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      btn_sync_q   <= '0;
      run_sync_q   <= '0;
      db_cnt_q     <= '0;
      btn_level_q  <= 1'b0;
      div_q        <= '0;
      state_q      <= IDLE;
      step_pulse_q <= 1'b0;
      step_count_q <= '0;
    end else begin
      btn_sync_q   <= btn_sync_d;
      run_sync_q   <= run_sync_d;
      db_cnt_q     <= db_cnt_d;
      btn_level_q  <= btn_level_d;
      div_q        <= div_d;
      state_q      <= state_d;
      step_pulse_q <= step_pulse_d;
      step_count_q <= step_count_d;
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// Scoreboard bench for step_pulse_gen: each stimulus pushes the clock edge and count
// at which a step pulse must appear; a negedge monitor pops and compares.
module tb_step_pulse_gen;

  localparam int CNT_W = 13;

  logic             clk = 1'b0;
  logic             rst;
  logic             btn_in;
  logic             run_en;
  logic             step_pulse;
  logic [CNT_W-1:0] step_count;
  logic             btn_level;
  logic             run_mode;

  typedef struct {
    int edge_no;
    int cnt;
  } exp_t;

  exp_t sb_q[$];
  int   edge_cnt = 0;
  int   exp_cnt  = 0;
  int   n_tests  = 0;
  int   n_fail   = 0;

  step_pulse_gen #(
    .SYNC_STAGES(2),
    .DEBOUNCE_CYCLES(4),
    .RUN_DIV(8),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .btn_in(btn_in),
    .run_en(run_en),
    .step_pulse(step_pulse),
    .step_count(step_count),
    .btn_level(btn_level),
    .run_mode(run_mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, obs, exp, edge_cnt);
    end
  endtask

  task automatic push_pulse(input int edge_no);
    exp_t e;
    exp_cnt   = (exp_cnt + 1) % (1 << CNT_W);
    e.edge_no = edge_no;
    e.cnt     = exp_cnt;
    sb_q.push_back(e);
  endtask

  task automatic wait_edges(input int m);
    repeat (m) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (step_pulse) begin
      if (sb_q.size() == 0) begin
        check("unexpected_pulse", edge_cnt, -1);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("pulse_edge", edge_cnt, e.edge_no);
        check("step_count", int'(step_count), e.cnt);
      end
    end
  end

  initial begin
    int n;
    int k;
    rst    = 1'b1;
    btn_in = 1'b1;
    run_en = 1'b1;

    // reset with both inputs high: everything stays low
    repeat (3) begin
      @(negedge clk);
      check("rst_pulse", int'(step_pulse), 0);
      check("rst_count", int'(step_count), 0);
      check("rst_level", int'(btn_level), 0);
      check("rst_run_mode", int'(run_mode), 0);
    end
    @(posedge clk);
    #1;
    rst    = 1'b0;
    btn_in = 1'b0;
    run_en = 1'b0;
    @(negedge clk);
    check("post_rst_pulse", int'(step_pulse), 0);
    check("post_rst_count", int'(step_count), 0);
    check("post_rst_level", int'(btn_level), 0);
    check("post_rst_run_mode", int'(run_mode), 0);
    wait_edges(5);

    // clean press: pulse 7 edges after the first sampling edge, none on release
    n = edge_cnt;
    btn_in = 1'b1;
    push_pulse(n + 7);
    wait_edges(20);
    check("press_level", int'(btn_level), 1);
    btn_in = 1'b0;
    wait_edges(15);
    check("release_level", int'(btn_level), 0);
    check("press_pending", sb_q.size(), 0);

    // bounce 1,0,1,0 then hold 1: one pulse, timed from the last rise
    n = edge_cnt;
    btn_in = 1'b1; wait_edges(1);
    btn_in = 1'b0; wait_edges(1);
    btn_in = 1'b1; wait_edges(1);
    btn_in = 1'b0; wait_edges(1);
    btn_in = 1'b1;
    push_pulse(n + 11);
    wait_edges(20);
    btn_in = 1'b0;
    wait_edges(15);
    check("bounce_pending", sb_q.size(), 0);

    // 3-cycle glitch is rejected
    btn_in = 1'b1;
    wait_edges(3);
    btn_in = 1'b0;
    wait_edges(15);
    check("glitch_level", int'(btn_level), 0);
    check("glitch_pending", sb_q.size(), 0);

    // run mode: entry 3 edges after run_en, pulses every 8; button ignored
    n = edge_cnt;
    run_en = 1'b1;
    for (int i = 1; i <= 4; i++) push_pulse(n + 3 + 8 * i);
    wait_edges(12);
    btn_in = 1'b1;
    wait_edges(10);
    btn_in = 1'b0;
    wait_edges(16);
    run_en = 1'b0;
    wait_edges(15);
    check("run_exit_mode", int'(run_mode), 0);
    check("run_exit_level", int'(btn_level), 0);
    check("run_pending", sb_q.size(), 0);
    check("run_count", int'(step_count), 6);

    // leave run mode with the button held: no pulse until release and new press
    n = edge_cnt;
    btn_in = 1'b1;
    push_pulse(n + 7);
    wait_edges(10);
    run_en = 1'b1;
    wait_edges(5);
    run_en = 1'b0;
    wait_edges(30);
    check("held_level", int'(btn_level), 1);
    btn_in = 1'b0;
    wait_edges(15);
    n = edge_cnt;
    btn_in = 1'b1;
    push_pulse(n + 7);
    wait_edges(12);
    btn_in = 1'b0;
    wait_edges(15);
    check("held_pending", sb_q.size(), 0);

    // wrap: run until the counter rolls over to zero
    k = (1 << CNT_W) - exp_cnt;
    n = edge_cnt;
    run_en = 1'b1;
    for (int i = 1; i <= k; i++) push_pulse(n + 3 + 8 * i);
    wait_edges(8 * k + 3);
    run_en = 1'b0;
    wait_edges(15);
    check("wrap_count", int'(step_count), 0);
    check("wrap_pending", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
